flag_register_unit: RTL and testbench

- Writer side of the N/Z/V condition flags consumed by the branch-resolution logic in decode.
- Computes flag values from the execute-stage ALU result and applies the per-opcode update mask.
- Holds the flags in a register and presents them as a 3-bit bus {Z,V,N}.
- Raises a one-cycle stall to decode when a branch would read flags still being produced in execute; freezes all flag state after HLT retires through execute.

---
 rtl/flag_register_unit.sv | 91 +++++++++
 tb/tb_flag_register_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/flag_register_unit.sv
// rtl/flag_register_unit.sv - N/Z/V condition-flag writer with branch stall and HLT freeze
//
// Ports:
//   clk          system clock, all state updates on rising edge
//   rst_n        synchronous active-low reset
//   ex_valid     execute stage holds a real instruction
//   ex_flush     execute instruction is squashed; it must not update flags
//   ex_opcode    opcode of the execute instruction
//   alu_result   ALU output of the execute instruction (WIDTH bits)
//   alu_ovfl     signed overflow from the ALU
//   hold         global pipeline freeze; no flag update this cycle
//   id_br_valid  decode holds a conditional branch that reads flags
//   flags        registered flags {Z,V,N}
//   br_stall     combinational; decode must not resolve its branch this cycle
//   halted       HLT has passed execute; flags frozen until reset
module flag_register_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_flush,
    input  logic [3:0]       ex_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ovfl,
    input  logic             hold,
    input  logic             id_br_valid,
    output logic [2:0]       flags,
    output logic             br_stall,
    output logic             halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t state;
    logic   write_all;   // ADD/SUB: Z, V and N all load
    logic   write_z;     // any opcode that loads Z (superset of write_all)
    logic   z_new;
    logic   n_new;
    logic   commit;

    always_comb begin
        write_all = 1'b0;
        write_z   = 1'b0;
        case (ex_opcode)
            4'b0000, 4'b0001: begin
                write_all = 1'b1;
                write_z   = 1'b1;
            end
            4'b0010, 4'b0100, 4'b0101, 4'b0110: begin
                write_z   = 1'b1;
            end
            default: begin
                write_all = 1'b0;
                write_z   = 1'b0;
            end
        endcase
    end

    assign z_new  = (alu_result == '0);
    assign n_new  = alu_result[WIDTH-1];
    assign halted = (state == HALT);
    assign commit = ex_valid & ~ex_flush & ~hold & ~halted;

    // Any Z-writer in execute stalls the branch regardless of which flag the
    // branch actually tests; there is no bypass, so the branch waits one cycle
    // for the registered value. rst_n gates it so decode sees no stall in reset.
    assign br_stall = rst_n & id_br_valid & ex_valid & ~ex_flush & ~halted & write_z;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags <= 3'b000;
            state <= RUN;
        end else if (commit) begin
            if (write_all) begin
                flags <= {z_new, alu_ovfl, n_new};
            end else if (write_z) begin
                flags[2] <= z_new;
            end
            if (ex_opcode == OP_HLT) begin
                state <= HALT;
            end
        end
    end

endmodule

// File: tb/tb_flag_register_unit.sv
// tb/tb_flag_register_unit.sv - table-driven self-checking bench for flag_register_unit
module tb_flag_register_unit;

    localparam int WIDTH = 16;

    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, XOR = 4'b0010, RED = 4'b0011,
                           SLL = 4'b0100, SRA = 4'b0101, ROR = 4'b0110, PAD = 4'b0111,
                           LW  = 4'b1000, LLB = 4'b1010, HLT = 4'b1111;

    logic             clk;
    logic             rst_n;
    logic             ex_valid;
    logic             ex_flush;
    logic [3:0]       ex_opcode;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovfl;
    logic             hold;
    logic             id_br_valid;
    logic [2:0]       flags;
    logic             br_stall;
    logic             halted;

    int checks;
    int failures;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        valid;
        logic        flush;
        logic [3:0]  op;
        logic [15:0] res;
        logic        ovfl;
        logic        hold;
        logic        br;
        logic        exp_stall;   // during the cycle the inputs are applied
        logic [2:0]  exp_flags;   // after the following rising edge
        logic        exp_halted;  // after the following rising edge
    } vec_t;

    vec_t vecs[$];

    flag_register_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_flush    (ex_flush),
        .ex_opcode   (ex_opcode),
        .alu_result  (alu_result),
        .alu_ovfl    (alu_ovfl),
        .hold        (hold),
        .id_br_valid (id_br_valid),
        .flags       (flags),
        .br_stall    (br_stall),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input string name, input logic r, input logic v, input logic f,
                           input logic [3:0] op, input logic [15:0] res, input logic ov,
                           input logic h, input logic br, input logic es,
                           input logic [2:0] ef, input logic eh);
        vec_t t;
        t.name = name; t.rst_n = r; t.valid = v; t.flush = f; t.op = op; t.res = res;
        t.ovfl = ov; t.hold = h; t.br = br; t.exp_stall = es; t.exp_flags = ef;
        t.exp_halted = eh;
        vecs.push_back(t);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive at negedge, sample stall just after, then sample registered state
    // one time unit after the next rising edge.
    task automatic apply(input vec_t t);
        @(negedge clk);
        rst_n = t.rst_n; ex_valid = t.valid; ex_flush = t.flush; ex_opcode = t.op;
        alu_result = t.res; alu_ovfl = t.ovfl; hold = t.hold; id_br_valid = t.br;
        #1;
        check1({t.name, ".br_stall"}, br_stall, t.exp_stall);
        @(posedge clk);
        #1;
        check3({t.name, ".flags"}, flags, t.exp_flags);
        check1({t.name, ".halted"}, halted, t.exp_halted);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; ex_valid = 1'b0; ex_flush = 1'b0; ex_opcode = 4'b0;
        alu_result = '0; alu_ovfl = 1'b0; hold = 1'b0; id_br_valid = 1'b0;

        //        name         rst v  f  op   result    ov h  br  stall flags  halt
        add_vec("rst0",        0, 1, 0, ADD, 16'h0000, 1, 0, 1, 0, 3'b000, 0);
        add_vec("rst1",        0, 0, 0, ADD, 16'h0000, 0, 0, 0, 0, 3'b000, 0);
        add_vec("add_zero",    1, 1, 0, ADD, 16'h0000, 0, 0, 0, 0, 3'b100, 0);
        add_vec("sub_neg_ov",  1, 1, 0, SUB, 16'h8000, 1, 0, 0, 0, 3'b011, 0);
        add_vec("xor_zero",    1, 1, 0, XOR, 16'h0000, 0, 0, 0, 0, 3'b111, 0);
        add_vec("sll_one",     1, 1, 0, SLL, 16'h0001, 0, 0, 0, 0, 3'b011, 0);
        add_vec("lw_zero",     1, 1, 0, LW,  16'h0000, 0, 0, 0, 0, 3'b011, 0);
        add_vec("paddsb_zero", 1, 1, 0, PAD, 16'h0000, 0, 0, 0, 0, 3'b011, 0);
        add_vec("add_br",      1, 1, 0, ADD, 16'h0005, 0, 0, 1, 1, 3'b000, 0);
        add_vec("llb_br",      1, 1, 0, LLB, 16'h0000, 0, 0, 1, 0, 3'b000, 0);
        add_vec("hold_c1",     1, 1, 0, ADD, 16'h0000, 1, 1, 1, 1, 3'b000, 0);
        add_vec("hold_c2",     1, 1, 0, ADD, 16'h0000, 1, 1, 1, 1, 3'b000, 0);
        add_vec("hold_c3",     1, 1, 0, ADD, 16'h0000, 1, 1, 1, 1, 3'b000, 0);
        add_vec("hold_rel",    1, 1, 0, ADD, 16'h0000, 1, 0, 1, 1, 3'b110, 0);
        add_vec("after_hold",  1, 0, 0, ADD, 16'h0000, 0, 0, 1, 0, 3'b110, 0);
        add_vec("flush_add",   1, 1, 1, ADD, 16'hFFFF, 0, 0, 1, 0, 3'b110, 0);
        add_vec("sra_br",      1, 1, 0, SRA, 16'h8000, 0, 0, 1, 1, 3'b010, 0);
        add_vec("ror_zero",    1, 1, 0, ROR, 16'h0000, 0, 0, 1, 1, 3'b110, 0);
        add_vec("red_br",      1, 1, 0, RED, 16'h0005, 1, 0, 1, 0, 3'b110, 0);
        add_vec("invalid_add", 1, 0, 0, ADD, 16'h0005, 0, 0, 1, 0, 3'b110, 0);
        add_vec("hlt_held",    1, 1, 0, HLT, 16'h0000, 0, 1, 1, 0, 3'b110, 0);
        add_vec("hlt_flushed", 1, 1, 1, HLT, 16'h0000, 0, 0, 1, 0, 3'b110, 0);
        add_vec("hlt",         1, 1, 0, HLT, 16'h0000, 0, 0, 1, 0, 3'b110, 1);
        add_vec("halt_add",    1, 1, 0, ADD, 16'h0000, 1, 0, 1, 0, 3'b110, 1);
        add_vec("halt_sub",    1, 1, 0, SUB, 16'h8000, 1, 0, 1, 0, 3'b110, 1);
        add_vec("halt_rst",    0, 1, 0, ADD, 16'h8000, 1, 0, 1, 0, 3'b000, 0);
        add_vec("add_neg",     1, 1, 0, ADD, 16'h8000, 0, 0, 0, 0, 3'b001, 0);
        add_vec("pend_hold",   1, 1, 0, ADD, 16'h0000, 1, 1, 1, 1, 3'b001, 0);
        add_vec("rst_midstall",0, 1, 0, ADD, 16'h0000, 1, 0, 1, 0, 3'b000, 0);
        add_vec("post_rst",    1, 0, 0, ADD, 16'h0000, 0, 0, 0, 0, 3'b000, 0);

        foreach (vecs[i]) apply(vecs[i]);

        // Hand-written: once halted, flags and halted stay frozen across a run
        // of mixed writers, and only reset releases the freeze.
        @(negedge clk);
        rst_n = 1'b1; ex_valid = 1'b1; ex_flush = 1'b0; hold = 1'b0; id_br_valid = 1'b1;
        ex_opcode = SUB; alu_result = 16'h8000; alu_ovfl = 1'b1;
        @(posedge clk); #1;
        check3("seq_sub.flags", flags, 3'b011);
        @(negedge clk);
        ex_opcode = HLT;
        @(posedge clk); #1;
        check1("seq_hlt.halted", halted, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ex_opcode = (k % 2 == 0) ? ADD : XOR;
            alu_result = '0; alu_ovfl = 1'b0;
            #1;
            check1("seq_frozen.br_stall", br_stall, 1'b0);
            @(posedge clk); #1;
            check3("seq_frozen.flags", flags, 3'b011);
            check1("seq_frozen.halted", halted, 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check1("seq_rst.br_stall", br_stall, 1'b0);
        @(posedge clk); #1;
        check3("seq_rst.flags", flags, 3'b000);
        check1("seq_rst.halted", halted, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
